// File: rtl/sr_dmem_ctrl.sv
// Multi-cycle data-memory controller: CPU load/store port to a word-wide 1-cycle-latency SRAM.
// Optional macro SR_DMEM_ALIGN_CHECK_EN rejects misaligned half/word accesses with err=1.
module sr_dmem_ctrl #(
  parameter int unsigned MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              op_byte,
  input  logic              op_half,
  input  logic              op_word,
  input  logic              sign,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned RAW = MEM_AW + 2;

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_RMW, ACK} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e          r_state;
  logic [RAW-1:0]  r_addr;
  logic [15:0]     r_wdata;
  size_e           r_size;
  logic            r_sign;
  logic [31:0]     r_rdata;
  logic            r_done;

  size_e           w_size;
  logic            w_reject;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_load;
  logic [31:0]     w_merge;
  logic            w_unused_addr;

  assign w_size        = op_byte ? SZ_BYTE : (op_half ? SZ_HALF : SZ_WORD);
  assign w_unused_addr = ^{addr[31:RAW], op_word};

`ifdef SR_DMEM_ALIGN_CHECK_EN
  logic r_err;
  logic w_misalign;

  assign w_misalign = ((w_size == SZ_HALF) && addr[0]) ||
                      ((w_size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign w_reject   = w_misalign;
  assign err        = r_err;

  // err reflects the most recently accepted request and is held through ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == IDLE) && req) begin
      r_err <= w_misalign;
    end
  end
`else
  // misaligned low bits are simply ignored by the lane selection below
  assign w_reject = 1'b0;
  assign err      = 1'b0;
`endif

  assign rdata = r_rdata;
  assign done  = r_done;
  assign stall = req & ~r_done;

  // lane extraction and sign/zero extension for loads
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_load = {{24{r_sign & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{r_sign & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  // read-modify-write merge of the latched sub-word into the fetched word
  always_comb begin
    w_merge = mem_rdata;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd1:    w_merge[15:8]  = r_wdata[7:0];
        2'd2:    w_merge[23:16] = r_wdata[7:0];
        2'd3:    w_merge[31:24] = r_wdata[7:0];
        default: w_merge[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata;
    end else begin
      w_merge[15:0] = r_wdata;
    end
  end

  // SRAM strobes: IDLE issues the first access off the live request, ST_RMW writes back
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_addr[RAW-1:2];
    mem_wdata = w_merge;
    case (r_state)
      IDLE: begin
        mem_addr  = addr[RAW-1:2];
        mem_wdata = wdata;
        if (req && !w_reject) begin
          mem_en = 1'b1;
          mem_we = we && (w_size == SZ_WORD);
        end
      end
      ST_RMW: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  // sequencing FSM with registered rdata/done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_WORD;
      r_sign  <= 1'b0;
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_addr  <= addr[RAW-1:0];
            r_wdata <= wdata[15:0];
            r_size  <= w_size;
            r_sign  <= sign;
            if (w_reject || (we && (w_size == SZ_WORD))) begin
              r_state <= ACK;
              r_done  <= 1'b1;
            end else if (!we) begin
              r_state <= LD_WAIT;
            end else begin
              r_state <= ST_RMW;
            end
          end
        end
        LD_WAIT: begin
          r_rdata <= w_load;
          r_state <= ACK;
          r_done  <= 1'b1;
        end
        ST_RMW: begin
          r_state <= ACK;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_dmem_ctrl.sv
// Directed self-checking bench for sr_dmem_ctrl with a behavioural 1-cycle-latency SRAM.
module tb_sr_dmem_ctrl;

  logic        clk, rst, req, we, op_byte, op_half, op_word, sign;
  logic [31:0] addr, wdata, rdata, mem_wdata, mem_rdata;
  logic        done, stall, err, mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem [0:1023];

  int checks = 0;
  int failures = 0;

  int          g_lat, g_en, g_we;
  logic [31:0] g_rdata;
  logic        g_err, g_stall_ok;
  logic [9:0]  g_weaddr;
  logic [31:0] exp8;

  sr_dmem_ctrl #(.MEM_AW(10)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .op_byte(op_byte), .op_half(op_half), .op_word(op_word), .sign(sign),
    .rdata(rdata), .done(done), .stall(stall), .err(err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // sz = {byte, half, word}; runs one request until done (bounded) and records observations
  task automatic access(input string name, input logic a_we, input logic [31:0] a_addr,
                        input logic [31:0] a_wdata, input logic [2:0] sz, input logic a_sign);
    g_lat = 0; g_en = 0; g_we = 0; g_stall_ok = 1'b1; g_weaddr = '0;
    g_rdata = '0; g_err = 1'b0;
    we = a_we; addr = a_addr; wdata = a_wdata;
    op_byte = sz[2]; op_half = sz[1]; op_word = sz[0]; sign = a_sign; req = 1'b1;
    for (int k = 1; k <= 8 && g_lat == 0; k++) begin
      @(negedge clk);
      if (mem_en) g_en++;
      if (mem_en && mem_we) begin g_we++; g_weaddr = mem_addr; end
      if (done) begin
        g_lat = k; g_rdata = rdata; g_err = err;
        if (stall) g_stall_ok = 1'b0;
      end else if (!stall) g_stall_ok = 1'b0;
      @(posedge clk); #1;
    end
    req = 1'b0;
    checks++;
    if (g_lat == 0) begin failures++; $display("FAIL %s timeout: done never seen within 8 cycles", name); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1;
    op_byte = 1'b0; op_half = 1'b0; op_word = 1'b1; sign = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0)   begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_strobes got en=%b we=%b exp 0/0", mem_en, mem_we); end
    req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_idle_stall got=%b exp=0", stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_word;
    access("st_w_preload", 1'b1, 32'h10, 32'h8899AABB, 3'b001, 1'b0);
    checks++; if (mem[4] !== 32'h8899AABB) begin failures++; $display("FAIL st_w_preload mem4 got=%h exp=8899aabb", mem[4]); end
    access("st_w", 1'b1, 32'h20, 32'hDEADBEEF, 3'b001, 1'b0);
    checks++; if (g_lat !== 2) begin failures++; $display("FAIL st_w_latency got=%0d exp=2", g_lat); end
    checks++; if (g_we !== 1 || g_weaddr !== 10'd8) begin failures++; $display("FAIL st_w_write got cnt=%0d addr=%0d exp 1/8", g_we, g_weaddr); end
    checks++; if (mem[8] !== 32'hDEADBEEF) begin failures++; $display("FAIL st_w_mem8 got=%h exp=deadbeef", mem[8]); end
    checks++; if (g_stall_ok !== 1'b1) begin failures++; $display("FAIL st_w_stall got=%b exp=1", g_stall_ok); end
  endtask

  task automatic test_loads;
    access("ld_b", 1'b0, 32'h12, 32'h0, 3'b100, 1'b1);
    checks++; if (g_rdata !== 32'hFFFFFF99) begin failures++; $display("FAIL ld_b_sext got=%h exp=ffffff99", g_rdata); end
    checks++; if (g_lat !== 3) begin failures++; $display("FAIL ld_b_latency got=%0d exp=3", g_lat); end
    checks++; if (g_stall_ok !== 1'b1) begin failures++; $display("FAIL ld_b_stall got=%b exp=1", g_stall_ok); end
    checks++; if (g_err !== 1'b0) begin failures++; $display("FAIL ld_b_err got=%b exp=0", g_err); end
    access("ld_h", 1'b0, 32'h12, 32'h0, 3'b010, 1'b0);
    checks++; if (g_rdata !== 32'h00008899) begin failures++; $display("FAIL ld_h_zext got=%h exp=00008899", g_rdata); end
    access("ld_h_s", 1'b0, 32'h10, 32'h0, 3'b010, 1'b1);
    checks++; if (g_rdata !== 32'hFFFFAABB) begin failures++; $display("FAIL ld_h_sext got=%h exp=ffffaabb", g_rdata); end
    access("ld_b_z", 1'b0, 32'h13, 32'h0, 3'b100, 1'b0);
    checks++; if (g_rdata !== 32'h00000088) begin failures++; $display("FAIL ld_b_zext got=%h exp=00000088", g_rdata); end
    access("ld_prio", 1'b0, 32'h11, 32'h0, 3'b111, 1'b1);
    checks++; if (g_rdata !== 32'hFFFFFFAA) begin failures++; $display("FAIL ld_size_priority got=%h exp=ffffffaa", g_rdata); end
    access("ld_w", 1'b0, 32'h10, 32'h0, 3'b000, 1'b1);
    checks++; if (g_rdata !== 32'h8899AABB) begin failures++; $display("FAIL ld_w_default got=%h exp=8899aabb", g_rdata); end
  endtask

  task automatic test_store_sub;
    access("st_b", 1'b1, 32'h21, 32'h00000055, 3'b100, 1'b0);
    checks++; if (mem[8] !== 32'hDEAD55EF) begin failures++; $display("FAIL st_b_mem8 got=%h exp=dead55ef", mem[8]); end
    checks++; if (g_lat !== 3 || g_we !== 1 || g_en !== 2) begin failures++; $display("FAIL st_b_seq got lat=%0d we=%0d en=%0d exp 3/1/2", g_lat, g_we, g_en); end
    checks++; if (g_rdata !== 32'h8899AABB) begin failures++; $display("FAIL st_b_rdata_held got=%h exp=8899aabb", g_rdata); end
    access("st_h", 1'b1, 32'h22, 32'hFFFF1234, 3'b010, 1'b0);
    checks++; if (mem[8] !== 32'h123455EF) begin failures++; $display("FAIL st_h_mem8 got=%h exp=123455ef", mem[8]); end
    checks++; if (g_lat !== 3) begin failures++; $display("FAIL st_h_latency got=%0d exp=3", g_lat); end
  endtask

  task automatic test_misaligned;
    access("st_mis", 1'b1, 32'h23, 32'hCAFEF00D, 3'b001, 1'b0);
    checks++; if (g_lat !== 2) begin failures++; $display("FAIL mis_latency got=%0d exp=2", g_lat); end
`ifdef SR_DMEM_ALIGN_CHECK_EN
    exp8 = 32'h123455EF;
    checks++; if (g_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", g_err); end
    checks++; if (g_en !== 0) begin failures++; $display("FAIL mis_no_access got en=%0d exp=0", g_en); end
`else
    exp8 = 32'hCAFEF00D;
    checks++; if (g_err !== 1'b0) begin failures++; $display("FAIL mis_err got=%b exp=0", g_err); end
    checks++; if (g_we !== 1 || g_weaddr !== 10'd8) begin failures++; $display("FAIL mis_write got cnt=%0d addr=%0d exp 1/8", g_we, g_weaddr); end
`endif
    checks++; if (mem[8] !== exp8) begin failures++; $display("FAIL mis_mem8 got=%h exp=%h", mem[8], exp8); end
  endtask

  task automatic test_reset_mid_rmw;
    we = 1'b1; addr = 32'h21; wdata = 32'h000000AA;
    op_byte = 1'b1; op_half = 1'b0; op_word = 1'b0; sign = 1'b0; req = 1'b1;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rmw_read got en=%b we=%b exp 1/0", mem_en, mem_we); end
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL rmw_write_phase got we=%b exp=1", mem_we); end
    rst = 1'b1; #1;
    checks++; if (mem_we !== 1'b0 || mem_en !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rmw_reset_drop got en=%b we=%b done=%b exp 0/0/0", mem_en, mem_we, done); end
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rmw_reset_no_done got=%b exp=0", done); end
    checks++; if (mem[8] !== exp8) begin failures++; $display("FAIL rmw_reset_mem8 got=%h exp=%h", mem[8], exp8); end
    @(posedge clk); #1;
    access("ld_after_rst", 1'b0, 32'h20, 32'h0, 3'b001, 1'b0);
    checks++; if (g_rdata !== exp8 || g_lat !== 3) begin failures++; $display("FAIL ld_after_rst got=%h lat=%0d exp=%h lat=3", g_rdata, g_lat, exp8); end
  endtask

  task automatic test_back_to_back;
    access("b2b_st", 1'b1, 32'h30, 32'h01020304, 3'b001, 1'b0);
    access("b2b_ld", 1'b0, 32'h31, 32'h0, 3'b100, 1'b0);
    checks++; if (g_rdata !== 32'h00000003 || g_lat !== 3) begin failures++; $display("FAIL b2b_ld got=%h lat=%0d exp=00000003 lat=3", g_rdata, g_lat); end
    access("b2b_sth", 1'b1, 32'h32, 32'h0000BEEF, 3'b010, 1'b0);
    checks++; if (mem[12] !== 32'hBEEF0304) begin failures++; $display("FAIL b2b_sth got=%h exp=beef0304", mem[12]); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_sub();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
